ipv4_checksum_arbiter: RTL and testbench

IPV4_CHECKSUM_ARBITER -- requirements
Module: ipv4_checksum_arbiter

---
 rtl/ipv4_checksum_arbiter.sv | 108 ++++++++++
 tb/tb_ipv4_checksum_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_checksum_arbiter.sv
// Round-robin arbiter that feeds requester headers into a shared, fixed-latency
// IPv4 checksum engine and routes each returned checksum back to its requester.
module ipv4_checksum_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ENG_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       sreset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*160-1:0]     req_hdr,
  output logic                       eng_hdr_tvalid,
  output logic [159:0]               eng_hdr_tdata,
  input  logic                       eng_chk_tvalid,
  input  logic [15:0]                eng_chk_tdata,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [15:0]                rsp_chksum,
  output logic                       err_orphan,
  output logic                       err_missing,
  output logic [31:0]                grant_count
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int DW  = $clog2(ENG_LATENCY + 1);

  logic [IDW-1:0]                     rr_ptr;
  logic [DW-1:0]                      drain;
  logic [NUM_REQ-1:0]                 gnt;
  logic [IDW-1:0]                     gnt_id;
  logic [159:0]                       hdr_sel;
  logic                               arb_en;
  logic                               hdr_vld;
  logic [IDW-1:0]                     hdr_id;
  logic [ENG_LATENCY-1:0]             tag_v;
  logic [ENG_LATENCY-1:0][IDW-1:0]    tag_id;
  logic                               mat_v;
  logic [IDW-1:0]                     mat_id;
  logic [31:0]                        cnt;

  // Grants are held off during reset and while pre-reset engine results drain.
  assign arb_en = !sreset && (drain == '0);

  always_comb begin
    int  idx;
    logic found;
    gnt     = '0;
    gnt_id  = '0;
    hdr_sel = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && arb_en && req_valid[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = IDW'(idx);
        hdr_sel     = req_hdr[160*idx +: 160];
      end
    end
  end

  assign req_ready      = gnt;
  assign eng_hdr_tvalid = hdr_vld && !sreset;
  assign mat_v          = tag_v[ENG_LATENCY-1];
  assign mat_id         = tag_id[ENG_LATENCY-1];
  assign grant_count    = cnt;

  always_ff @(posedge clk) begin
    if (sreset) begin
      rr_ptr        <= '0;
      drain         <= DW'(ENG_LATENCY);
      hdr_vld       <= 1'b0;
      hdr_id        <= '0;
      eng_hdr_tdata <= '0;
      tag_v         <= '0;
      tag_id        <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_chksum    <= '0;
      err_orphan    <= 1'b0;
      err_missing   <= 1'b0;
      cnt           <= '0;
    end else begin
      if (drain != '0) drain <= drain - DW'(1);
      hdr_vld <= |gnt;
      if (|gnt) begin
        rr_ptr        <= (gnt_id == IDW'(NUM_REQ-1)) ? '0 : gnt_id + IDW'(1);
        hdr_id        <= gnt_id;
        eng_hdr_tdata <= hdr_sel;
        cnt           <= cnt + 32'd1;
      end
      // Tag pipe mirrors the engine so the matured tag lines up with its result.
      for (int k = ENG_LATENCY-1; k > 0; k--) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      tag_v[0]  <= eng_hdr_tvalid;
      tag_id[0] <= hdr_id;
      rsp_valid   <= mat_v && eng_chk_tvalid;
      if (mat_v && eng_chk_tvalid) begin
        rsp_id     <= mat_id;
        rsp_chksum <= eng_chk_tdata;
      end
      err_missing <= mat_v && !eng_chk_tvalid;
      err_orphan  <= !mat_v && eng_chk_tvalid && (drain == '0);
    end
  end
endmodule

// File: tb/tb_ipv4_checksum_arbiter.sv
// Directed bench: arbiter plus a behavioural fixed-latency checksum engine that
// can drop a result or inject a spurious one.
module tb_ipv4_checksum_arbiter;
  localparam int N = 4;
  localparam int L = 2;
  localparam logic [159:0] S1_HDR = 160'h4500_0073_0000_4000_4011_0000_c0a8_0001_c0a8_00c7;

  logic             clk = 1'b0;
  logic             sreset;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*160-1:0] req_hdr;
  logic             eng_hdr_tvalid;
  logic [159:0]     eng_hdr_tdata;
  logic             eng_chk_tvalid;
  logic [15:0]      eng_chk_tdata;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [15:0]      rsp_chksum;
  logic             err_orphan;
  logic             err_missing;
  logic [31:0]      grant_count;

  ipv4_checksum_arbiter #(.NUM_REQ(N), .ENG_LATENCY(L)) dut (
    .clk(clk), .sreset(sreset), .req_valid(req_valid), .req_ready(req_ready),
    .req_hdr(req_hdr), .eng_hdr_tvalid(eng_hdr_tvalid), .eng_hdr_tdata(eng_hdr_tdata),
    .eng_chk_tvalid(eng_chk_tvalid), .eng_chk_tdata(eng_chk_tdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_chksum(rsp_chksum),
    .err_orphan(err_orphan), .err_missing(err_missing), .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  // Engine model: not reset by sreset, so in-flight results survive a reset.
  function automatic logic [15:0] csum(input logic [159:0] h);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < 10; k++) s = s + 32'(h[16*k +: 16]);
    s = (s & 32'hFFFF) + (s >> 16);
    s = (s & 32'hFFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  logic                kill_arm, inject;
  logic [L-1:0]        ev = '0, ek = '0;
  logic [L-1:0][15:0]  ed = '0;
  always @(posedge clk) begin
    for (int k = L-1; k > 0; k--) begin
      ev[k] <= ev[k-1]; ek[k] <= ek[k-1]; ed[k] <= ed[k-1];
    end
    ev[0] <= eng_hdr_tvalid;
    ek[0] <= kill_arm;
    ed[0] <= csum(eng_hdr_tdata);
  end
  assign eng_chk_tvalid = (ev[L-1] && !ek[L-1]) || inject;
  assign eng_chk_tdata  = ev[L-1] ? ed[L-1] : 16'h5A5A;

  // Event logs, sampled on the falling edge.
  int cyc = 0;
  int rsp_id_q[$], rsp_cy_q[$], gnt_id_q[$], gnt_cy_q[$], mis_q[$], orp_q[$];
  logic [15:0] rsp_ck_q[$];
  int onehot_bad = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_id_q.push_back(int'(rsp_id)); rsp_ck_q.push_back(rsp_chksum); rsp_cy_q.push_back(cyc);
    end
    if (err_missing) mis_q.push_back(cyc);
    if (err_orphan)  orp_q.push_back(cyc);
    if (req_ready != '0) begin
      if ($countones(req_ready) != 1) onehot_bad++;
      for (int k = 0; k < N; k++)
        if (req_ready[k]) begin gnt_id_q.push_back(k); gnt_cy_q.push_back(cyc); end
    end
  end

  int nvec = 0, nerr = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs();
    rsp_id_q.delete(); rsp_cy_q.delete(); rsp_ck_q.delete();
    gnt_id_q.delete(); gnt_cy_q.delete(); mis_q.delete(); orp_q.delete();
  endtask

  // Raise requester i until granted; returns the grant cycle.
  task automatic send(input int i, input logic [159:0] h, output int gc);
    req_hdr[160*i +: 160] = h;
    req_valid[i] = 1'b1;
    gc = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (req_ready[i]) begin gc = cyc; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    if (gc < 0) chk("send_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, g, g2, ic, c;
    sreset = 1'b1; req_valid = '0; req_hdr = '0; kill_arm = 1'b0; inject = 1'b0;
    tick(3);
    req_valid = '1;
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_hvld", eng_hdr_tvalid, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_gcnt", grant_count, 0);
    @(posedge clk); #1;
    req_valid = '0; sreset = 1'b0; r = cyc;

    // Scenario 1: single header, checksum B861, grant held off by drain
    clear_logs();
    send(2, S1_HDR, g);
    chk("s1_gnt_cyc", 64'(g - r), L);
    tick(L + 4);
    chk("s1_nrsp", rsp_id_q.size(), 1);
    if (rsp_id_q.size() > 0) begin
      chk("s1_id", rsp_id_q[0], 2);
      chk("s1_ck", rsp_ck_q[0], 16'hB861);
      chk("s1_lat", 64'(rsp_cy_q[0] - g), L + 2);
    end
    chk("s1_gcnt", grant_count, 1);

    // Scenario 2: all requesters valid for 8 grants after reset
    sreset = 1'b1; tick(1); clear_logs(); sreset = 1'b0; r = cyc;
    for (int i = 0; i < N; i++) req_hdr[160*i +: 160] = {144'h0, 16'h0100 + 16'(i)};
    req_valid = '1;
    tick(L + 8);
    req_valid = '0;
    tick(L + 4);
    chk("s2_ngnt", gnt_id_q.size(), 8);
    chk("s2_nrsp", rsp_id_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < gnt_id_q.size()) begin
        chk("s2_gid", gnt_id_q[k], k % 4);
        chk("s2_gcy", gnt_cy_q[k], r + L + k);
      end
      if (k < rsp_id_q.size()) begin
        chk("s2_rid", rsp_id_q[k], k % 4);
        chk("s2_rck", rsp_ck_q[k], 16'hFEFF - (k % 4));
        chk("s2_rcy", rsp_cy_q[k], r + 2*L + 2 + k);
      end
    end

    // Scenario 3: engine drops one result, then emits a spurious one
    clear_logs();
    kill_arm = 1'b1;
    send(1, S1_HDR, g);
    tick(1);
    kill_arm = 1'b0;
    tick(L + 3);
    chk("s3_nmis", mis_q.size(), 1);
    if (mis_q.size() > 0) chk("s3_miscy", 64'(mis_q[0] - g), L + 2);
    chk("s3_nrsp", rsp_id_q.size(), 0);
    ic = cyc; inject = 1'b1;
    tick(1);
    inject = 1'b0;
    tick(3);
    chk("s3_norp", orp_q.size(), 1);
    if (orp_q.size() > 0) chk("s3_orpcy", orp_q[0], ic + 1);
    chk("s3_nmis2", mis_q.size(), 1);

    // Scenario 6: requester 1 raises and drops while 3 holds priority
    clear_logs();
    send(2, S1_HDR, g2);
    req_hdr[160*3 +: 160] = {144'h0, 16'h0103};
    req_valid[3] = 1'b1; req_valid[1] = 1'b1;
    @(negedge clk);
    chk("s6_ready", req_ready, 4'b1000);
    @(posedge clk); #1;
    req_valid = '0;
    tick(L + 4);
    chk("s6_ngnt", gnt_id_q.size(), 2);
    if (gnt_id_q.size() > 1) chk("s6_gid", gnt_id_q[1], 3);
    chk("s6_nrsp", rsp_id_q.size(), 2);
    if (rsp_id_q.size() > 1) chk("s6_rid", rsp_id_q[1], 3);
    chk("s6_err", 64'(orp_q.size() + mis_q.size()), 0);

    // Scenario 5: grant counter wrap
    clear_logs();
    force dut.cnt = 32'hFFFF_FFFF;
    tick(1);
    release dut.cnt;
    @(negedge clk);
    chk("s5_pre", grant_count, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    send(0, S1_HDR, g);
    chk("s5_wrap", grant_count, 0);
    tick(L + 4);

    // Scenario 4: reset with two headers in flight
    clear_logs();
    req_hdr[160*1 +: 160] = {144'h0, 16'h0101};
    req_hdr[160*0 +: 160] = {144'h0, 16'h0100};
    c = cyc;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("s4_g1", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("s4_g0", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    tick(1);
    sreset = 1'b1;
    tick(1);
    sreset = 1'b0; r = cyc;
    req_valid = '1;
    tick(L);
    @(negedge clk);
    chk("s4_first", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    tick(L + 4);
    chk("s4_ngnt", gnt_id_q.size(), 3);
    if (gnt_id_q.size() > 2) chk("s4_gcy", gnt_cy_q[2], r + L);
    chk("s4_nrsp", rsp_id_q.size(), 1);
    if (rsp_id_q.size() > 0) begin
      chk("s4_rid", rsp_id_q[0], 0);
      chk("s4_rcy", rsp_cy_q[0], r + 2*L + 2);
    end
    chk("s4_orp", orp_q.size(), 0);
    chk("s4_mis", mis_q.size(), 0);
    chk("c4_gcnt", grant_count, 1);

    chk("onehot", onehot_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
